// File: rtl/chess_clock_timebase.sv
// Chess-timer timebase: prescaler tick plus two saturating per-player countdown counters.
// Optional turn-start grace period is compiled in with `define TIMER_GRACE_EN.
module chess_clock_timebase #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1,
  parameter int CNT_W       = 10,
  parameter int START_TIME  = 300,
  parameter int GRACE_TICKS = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       load_counters,
  input  logic [1:0]       en_counters,
  input  logic [CNT_W-1:0] start_value,
  output logic [CNT_W-1:0] counter_1,
  output logic [CNT_W-1:0] counter_2,
  output logic             tick,
  output logic [1:0]       expired
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    TERM  = PW'(DIV - 1);
  localparam logic [CNT_W-1:0] START = CNT_W'(START_TIME);

  logic [PW-1:0]    presc_q, presc_d;
  logic [1:0]       en_prev_q, en_prev_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;
  logic             run_mode;
  logic             en_chg;
  logic             dec_ok;

  // Exactly one player running is run mode; 00 and 11 both hold.
  assign run_mode = en_counters[0] ^ en_counters[1];
  assign en_chg   = (en_counters != en_prev_q);
  assign tick     = run_mode && !en_chg && (presc_q == TERM);

  always_comb begin
    en_prev_d = en_counters;
    presc_d   = presc_q + 1'b1;
    if (!run_mode || en_chg || (presc_q == TERM)) begin
      presc_d = '0;
    end
  end

`ifdef TIMER_GRACE_EN
  localparam logic [2:0] GRACE_MAX = 3'(GRACE_TICKS);
  logic [2:0] grace_q, grace_d;

  assign dec_ok = (grace_q >= GRACE_MAX);

  always_comb begin
    grace_d = grace_q;
    if (en_chg) begin
      grace_d = '0;
    end else if (tick && !dec_ok) begin
      grace_d = grace_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grace_q <= '0;
    end else begin
      grace_q <= grace_d;
    end
  end
`else
  assign dec_ok = 1'b1;
`endif

  // Load wins over decrement; decrement stops at zero instead of wrapping.
  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    if (load_counters[0]) begin
      cnt1_d = start_value;
    end else if (en_counters[0] && tick && dec_ok && (cnt1_q != '0)) begin
      cnt1_d = cnt1_q - 1'b1;
    end
    if (load_counters[1]) begin
      cnt2_d = start_value;
    end else if (en_counters[1] && tick && dec_ok && (cnt2_q != '0)) begin
      cnt2_d = cnt2_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q   <= '0;
      en_prev_q <= 2'b00;
      cnt1_q    <= START;
      cnt2_q    <= START;
    end else begin
      presc_q   <= presc_d;
      en_prev_q <= en_prev_d;
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
    end
  end

  assign counter_1 = cnt1_q;
  assign counter_2 = cnt2_q;
  assign expired   = {(cnt2_q == '0), (cnt1_q == '0)};

endmodule

// File: tb/tb_chess_clock_timebase.sv
// Randomized bench for chess_clock_timebase against a turn-level behavioural model.
module tb_chess_clock_timebase;

  localparam int CLK_HZ = 4;
  localparam int TICK_HZ = 1;
  localparam int CNT_W = 10;
  localparam int START_TIME = 300;
  localparam int GRACE_TICKS = 2;
  localparam int DIV = CLK_HZ / TICK_HZ;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       load_counters;
  logic [1:0]       en_counters;
  logic [CNT_W-1:0] start_value;
  logic [CNT_W-1:0] counter_1;
  logic [CNT_W-1:0] counter_2;
  logic             tick;
  logic [1:0]       expired;

  chess_clock_timebase #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .CNT_W(CNT_W),
    .START_TIME(START_TIME), .GRACE_TICKS(GRACE_TICKS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .load_counters(load_counters),
    .en_counters(en_counters), .start_value(start_value),
    .counter_1(counter_1), .counter_2(counter_2), .tick(tick), .expired(expired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: remaining time per player, mode of the previous cycle,
  // cycles elapsed since the current turn began, ticks seen in this turn.
  int   m_c[2];
  logic [1:0] m_prev;
  int   m_k;
  int   m_g;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_c[0] = START_TIME;
    m_c[1] = START_TIME;
    m_prev = 2'b00;
    m_k    = 0;
    m_g    = 0;
  endtask

  task automatic step(input logic [1:0] en, input logic [1:0] ld, input logic [CNT_W-1:0] sv);
    bit chg, run, e_tick, ok;
    int k, g;
    @(negedge clk);
    en_counters   = en;
    load_counters = ld;
    start_value   = sv;
    #1;
    chg = (en != m_prev);
    run = (en == 2'b01) || (en == 2'b10);
    k   = chg ? 0 : m_k + 1;
    // A full tick period elapses after each turn start, then every DIV clocks.
    e_tick = run && !chg && (k > 0) && (k % DIV == 0);
    g = chg ? 0 : m_g;
`ifdef TIMER_GRACE_EN
    ok = (g >= GRACE_TICKS);
`else
    ok = 1'b1;
`endif
    chk("tick", int'(tick), int'(e_tick));
    chk("counter_1", int'(counter_1), m_c[0]);
    chk("counter_2", int'(counter_2), m_c[1]);
    chk("expired", int'(expired), int'({m_c[1] == 0, m_c[0] == 0}));
    for (int i = 0; i < 2; i++) begin
      if (ld[i]) m_c[i] = int'(sv);
      else if (en[i] && e_tick && ok && m_c[i] > 0) m_c[i] = m_c[i] - 1;
    end
    if (e_tick && !ok) g = g + 1;
    m_prev = en;
    m_k    = k;
    m_g    = g;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_counter_1", int'(counter_1), START_TIME);
    chk("rst_counter_2", int'(counter_2), START_TIME);
    chk("rst_tick", int'(tick), 0);
    chk("rst_expired", int'(expired), 0);
    en_counters   = 2'b00;
    load_counters = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) step(2'b00, 2'b00, '0);
  endtask

  initial begin
    logic [1:0] en_r;
    logic [1:0] ld_r;
    logic [CNT_W-1:0] sv_r;
    int len;
    reset_n       = 1'b0;
    load_counters = 2'b00;
    en_counters   = 2'b00;
    start_value   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("init_counter_1", int'(counter_1), START_TIME);
    chk("init_tick", int'(tick), 0);
    reset_n = 1'b1;

    // Load 5 into both, run player 1 down to zero and past it.
    step(2'b00, 2'b11, 10'd5);
    for (int i = 0; i < 45; i++) step(2'b01, 2'b00, '0);
    // Hand the turn over partway through a tick period.
    for (int i = 0; i < 6; i++) step(2'b10, 2'b00, '0);
    step(2'b10, 2'b01, 10'd9);
    for (int i = 0; i < 10; i++) step(2'b01, 2'b00, '0);
    for (int i = 0; i < 12; i++) step(2'b11, 2'b00, '0);
    // Load with start_value 0 expires on the next clock.
    step(2'b00, 2'b10, 10'd0);
    step(2'b00, 2'b00, '0);
    mid_reset();

    for (int seg = 0; seg < 300; seg++) begin
      en_r = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) en_r = $urandom_range(0, 1) ? 2'b01 : 2'b10;
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        ld_r = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        sv_r = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 6));
        step(en_r, ld_r, sv_r);
      end
      if ($urandom_range(0, 39) == 0) mid_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
